pl_ifid_fq: RTL and testbench

Parametrised IF/ID pipeline stage with an instruction fetch queue of depth FQ_DEPTH between instruction memory and decode. It adds a valid/ready fetch handshake, a decode stall input and PC tagging, none of which the single-register IF/ID stage has. It decodes the queue head combinationally for the forwarding unit and registers decoded fields into the IF/ID pipeline register. A taken branch in EX flushes the whole queue and the pipeline register.

---
 rtl/pl_ifid_fq.sv | 110 +++++++++++
 tb/tb_pl_ifid_fq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pl_ifid_fq.sv
// pl_ifid_fq: IF/ID stage with fetch queue; ports: fetch handshake in, decode-head peek out, IFID_* pipeline register out
module pl_ifid_fq #(
  parameter int PROG_CTR_WID = 10,
  parameter int NUM_DOMAINS = 1,
  parameter int FQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid_in,
  input  logic [15:0]                   instr_in,
  input  logic [PROG_CTR_WID-1:0]       instr_pc_in,
  output logic                          fetch_ready,
  input  logic                          stall_ID,
  input  logic                          branch_taken_EX,
  input  logic [NUM_DOMAINS*8-1:0]      op1_data,
  input  logic [NUM_DOMAINS*8-1:0]      op2_data,
  output logic [2:0]                    op1_addr_IFID,
  output logic [2:0]                    op2_addr_IFID,
  output logic                          load_true_IFID,
  output logic [$clog2(FQ_DEPTH):0]     fq_count,
  output logic                          IFID_valid,
  output logic [4:0]                    IFID_opcode,
  output logic [2:0]                    IFID_res_addr,
  output logic [2:0]                    IFID_op1_addr,
  output logic [2:0]                    IFID_op2_addr,
  output logic [7:0]                    IFID_imm,
  output logic [7:0]                    IFID_st_addr,
  output logic [PROG_CTR_WID-1:0]       IFID_br_tgt,
  output logic [PROG_CTR_WID-1:0]       IFID_pc,
  output logic                          IFID_wr_rf,
  output logic                          IFID_is_jump,
  output logic                          IFID_is_uncond,
  output logic                          IFID_is_store,
  output logic                          IFID_is_load,
  output logic                          IFID_ld_imm,
  output logic [NUM_DOMAINS*8-1:0]      op1_dout_IFID,
  output logic [NUM_DOMAINS*8-1:0]      op2_dout_IFID
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = NUM_DOMAINS * 8;
  localparam int RW = 5 + 3 + 3 + 3 + 8 + 8 + 2 * PROG_CTR_WID + 6 + 2 * DW;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
  logic [15:0]             instr_mem [FQ_DEPTH];
  logic [PROG_CTR_WID-1:0] pc_mem [FQ_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q;
  logic [RW-1:0]           ifid_q, ifid_d;
  logic                    push, pop, head_vld;
  logic [15:0]             head;
  logic [4:0]              opc;
  logic                    wr_rf, is_jump, is_unc, is_st, is_ld, is_ldi;
  assign fetch_ready = (count_q < FULL) && !rst;
  // a flush swallows any push offered in the same cycle
  assign push = instr_valid_in && fetch_ready && !branch_taken_EX;
  assign pop = head_vld && !stall_ID && !branch_taken_EX;
  always_comb begin
    head = instr_mem[rd_ptr_q];
    head_vld = count_q != '0;
    opc = head[15:11];
    wr_rf = opc inside {[5'h01:5'h06], [5'h0A:5'h0C], 5'h08, 5'h12};
    is_jump = opc inside {5'h07, [5'h0E:5'h11]};
    is_unc = opc == 5'h07;
    is_st = opc == 5'h09;
    is_ld = opc == 5'h08;
    is_ldi = opc == 5'h12;
    count_d = count_q + CW'(push) - CW'(pop);
    ifid_d = {opc, head[10:8], head[2:0], head[6:4], head[7:0], head[10:3],
              PROG_CTR_WID'(head[9:0]), pc_mem[rd_ptr_q],
              wr_rf, is_jump, is_unc, is_st, is_ld, is_ldi, op1_data, op2_data};
  end
  assign op1_addr_IFID = head_vld ? head[2:0] : 3'd0;
  assign op2_addr_IFID = head_vld ? head[6:4] : 3'd0;
  assign load_true_IFID = head_vld && is_ld;
  assign fq_count = count_q;
  assign IFID_valid = valid_q;
  assign {IFID_opcode, IFID_res_addr, IFID_op1_addr, IFID_op2_addr, IFID_imm, IFID_st_addr,
          IFID_br_tgt, IFID_pc, IFID_wr_rf, IFID_is_jump, IFID_is_uncond, IFID_is_store,
          IFID_is_load, IFID_ld_imm, op1_dout_IFID, op2_dout_IFID} = ifid_q;
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= instr_in;
      pc_mem[wr_ptr_q] <= instr_pc_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ifid_q <= '0;
    end else if (branch_taken_EX) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ifid_q <= ifid_d;
      end
      // an empty, unstalled queue inserts a bubble; fields other than valid hold
      if (!stall_ID) valid_q <= head_vld;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_pl_ifid_fq.sv
// tb_pl_ifid_fq: directed bench with a queue-based reference model and per-cycle compare
module tb_pl_ifid_fq;
  localparam int PCW = 12;
  localparam int ND = 3;
  localparam int DEP = 4;
  localparam int DW = ND * 8;
  logic clk = 0, rst = 1;
  logic instr_valid_in = 0, stall_ID = 0, branch_taken_EX = 0;
  logic [15:0] instr_in = 0;
  logic [PCW-1:0] instr_pc_in = 0;
  logic [DW-1:0] op1_data = 0, op2_data = 0;
  logic fetch_ready, load_true_IFID, IFID_valid;
  logic [2:0] op1_addr_IFID, op2_addr_IFID, IFID_res_addr, IFID_op1_addr, IFID_op2_addr;
  logic [$clog2(DEP):0] fq_count;
  logic [4:0] IFID_opcode;
  logic [7:0] IFID_imm, IFID_st_addr;
  logic [PCW-1:0] IFID_br_tgt, IFID_pc;
  logic IFID_wr_rf, IFID_is_jump, IFID_is_uncond, IFID_is_store, IFID_is_load, IFID_ld_imm;
  logic [DW-1:0] op1_dout_IFID, op2_dout_IFID;
  int n_cmp = 0, n_bad = 0;

  pl_ifid_fq #(.PROG_CTR_WID(PCW), .NUM_DOMAINS(ND), .FQ_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .instr_valid_in(instr_valid_in), .instr_in(instr_in),
    .instr_pc_in(instr_pc_in), .fetch_ready(fetch_ready), .stall_ID(stall_ID),
    .branch_taken_EX(branch_taken_EX), .op1_data(op1_data), .op2_data(op2_data),
    .op1_addr_IFID(op1_addr_IFID), .op2_addr_IFID(op2_addr_IFID), .load_true_IFID(load_true_IFID),
    .fq_count(fq_count), .IFID_valid(IFID_valid), .IFID_opcode(IFID_opcode),
    .IFID_res_addr(IFID_res_addr), .IFID_op1_addr(IFID_op1_addr), .IFID_op2_addr(IFID_op2_addr),
    .IFID_imm(IFID_imm), .IFID_st_addr(IFID_st_addr), .IFID_br_tgt(IFID_br_tgt), .IFID_pc(IFID_pc),
    .IFID_wr_rf(IFID_wr_rf), .IFID_is_jump(IFID_is_jump), .IFID_is_uncond(IFID_is_uncond),
    .IFID_is_store(IFID_is_store), .IFID_is_load(IFID_is_load), .IFID_ld_imm(IFID_ld_imm),
    .op1_dout_IFID(op1_dout_IFID), .op2_dout_IFID(op2_dout_IFID));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a plain queue of {pc, instr} plus the last instruction handed to decode
  logic [27:0] m_q[$];
  logic m_valid = 0;
  int m_instr = 0, m_pc = 0, m_d1 = 0, m_d2 = 0;

  function automatic logic [5:0] flags(input int op);
    logic wr, jmp, unc, st, ld, li;
    wr = (op >= 1 && op <= 6) || (op >= 10 && op <= 12) || op == 8 || op == 18;
    jmp = op == 7 || (op >= 14 && op <= 17);
    unc = op == 7;
    st = op == 9;
    ld = op == 8;
    li = op == 18;
    return {wr, jmp, unc, st, ld, li};
  endfunction

  always @(posedge clk) begin
    logic [27:0] e;
    int sz;
    sz = m_q.size();
    if (rst) begin
      m_q.delete();
      m_valid = 0; m_instr = 0; m_pc = 0; m_d1 = 0; m_d2 = 0;
    end else if (branch_taken_EX) begin
      m_q.delete();
      m_valid = 0;
    end else begin
      if (!stall_ID) begin
        if (sz > 0) begin
          e = m_q.pop_front();
          m_instr = int'(e) & 16'hFFFF;
          m_pc = int'(e >> 16);
          m_d1 = int'(op1_data);
          m_d2 = int'(op2_data);
          m_valid = 1;
        end else m_valid = 0;
      end
      if (instr_valid_in && sz < DEP) m_q.push_back({instr_pc_in, instr_in});
    end
  end

  always @(posedge clk) begin
    int hd, op;
    logic [5:0] f;
    #2;
    hd = m_q.size() > 0 ? int'(m_q[0]) & 16'hFFFF : 0;
    chk("fq_count", 32'(fq_count), 32'(m_q.size()));
    chk("fetch_ready", 32'(fetch_ready), 32'(!rst && m_q.size() < DEP));
    chk("op1_addr_IFID", 32'(op1_addr_IFID), m_q.size() > 0 ? hd % 8 : 0);
    chk("op2_addr_IFID", 32'(op2_addr_IFID), m_q.size() > 0 ? (hd / 16) % 8 : 0);
    chk("load_true_IFID", 32'(load_true_IFID), 32'(m_q.size() > 0 && hd / 2048 == 8));
    op = m_instr / 2048;
    f = flags(op);
    chk("IFID_valid", 32'(IFID_valid), 32'(m_valid));
    chk("IFID_opcode", 32'(IFID_opcode), op);
    chk("IFID_res_addr", 32'(IFID_res_addr), (m_instr / 256) % 8);
    chk("IFID_op1_addr", 32'(IFID_op1_addr), m_instr % 8);
    chk("IFID_op2_addr", 32'(IFID_op2_addr), (m_instr / 16) % 8);
    chk("IFID_imm", 32'(IFID_imm), m_instr % 256);
    chk("IFID_st_addr", 32'(IFID_st_addr), (m_instr / 8) % 256);
    chk("IFID_br_tgt", 32'(IFID_br_tgt), m_instr % 1024);
    chk("IFID_pc", 32'(IFID_pc), m_pc);
    chk("IFID_flags", 32'({IFID_wr_rf, IFID_is_jump, IFID_is_uncond, IFID_is_store, IFID_is_load, IFID_ld_imm}), 32'(f));
    chk("op1_dout_IFID", 32'(op1_dout_IFID), m_d1);
    chk("op2_dout_IFID", 32'(op2_dout_IFID), m_d2);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [PCW-1:0] pc);
    instr_valid_in = v; instr_in = ins; instr_pc_in = pc;
  endtask

  logic [4:0] ops[10] = '{5'h0D, 5'h12, 5'h09, 5'h0E, 5'h11, 5'h1F, 5'h00, 5'h0A, 5'h0C, 5'h10};

  initial begin
    repeat (2) step();
    chk("lit_reset_valid", 32'(IFID_valid), 0);
    chk("lit_reset_count", 32'(fq_count), 0);
    chk("lit_reset_ready", 32'(fetch_ready), 0);
    rst = 0;
    // first instruction, one edge to the queue and one to IFID
    drive(1, 16'h0A12, 12'd5);
    step();
    drive(0, 0, 0);
    chk("lit_t1_head_op1", 32'(op1_addr_IFID), 2);
    step();
    chk("lit_t1_valid", 32'(IFID_valid), 1);
    chk("lit_t1_opcode", 32'(IFID_opcode), 5'h01);
    chk("lit_t1_res", 32'(IFID_res_addr), 2);
    chk("lit_t1_op1", 32'(IFID_op1_addr), 2);
    chk("lit_t1_op2", 32'(IFID_op2_addr), 1);
    chk("lit_t1_wr_rf", 32'(IFID_wr_rf), 1);
    chk("lit_t1_pc", 32'(IFID_pc), 5);
    // stalled fill past capacity
    stall_ID = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, {5'h02, 3'(i), 8'(i * 17)}, PCW'(10 + i));
      step();
    end
    drive(0, 0, 0);
    chk("lit_full_count", 32'(fq_count), 4);
    chk("lit_full_ready", 32'(fetch_ready), 0);
    chk("lit_stall_pc", 32'(IFID_pc), 5);
    chk("lit_stall_valid", 32'(IFID_valid), 1);
    stall_ID = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lit_drain_pc", 32'(IFID_pc), 10 + k);
      chk("lit_drain_count", 32'(fq_count), 3 - k);
    end
    step();
    chk("lit_bubble_valid", 32'(IFID_valid), 0);
    // flush with a simultaneous push
    stall_ID = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h1111, PCW'(20 + i));
      step();
    end
    branch_taken_EX = 1;
    drive(1, 16'hBEEF, 12'd99);
    step();
    branch_taken_EX = 0; stall_ID = 0;
    drive(0, 0, 0);
    chk("lit_flush_count", 32'(fq_count), 0);
    chk("lit_flush_valid", 32'(IFID_valid), 0);
    chk("lit_flush_ready", 32'(fetch_ready), 1);
    repeat (2) step();
    chk("lit_flush_gone_valid", 32'(IFID_valid), 0);
    chk("lit_flush_gone_pc", 32'(IFID_pc), 13);
    // unconditional jump, target zero-extended to 12 bits
    drive(1, 16'h3A05, 12'h030);
    step();
    drive(0, 0, 0);
    step();
    chk("lit_jmp_tgt", 32'(IFID_br_tgt), 12'h205);
    chk("lit_jmp_jump", 32'(IFID_is_jump), 1);
    chk("lit_jmp_unc", 32'(IFID_is_uncond), 1);
    chk("lit_jmp_wr", 32'(IFID_wr_rf), 0);
    // RLOAD head peek and operand capture
    drive(1, 16'h4321, 12'h040);
    op1_data = 24'hABCDEF; op2_data = 24'h123456;
    step();
    drive(0, 0, 0);
    chk("lit_ld_true", 32'(load_true_IFID), 1);
    chk("lit_ld_op1", 32'(op1_addr_IFID), 1);
    chk("lit_ld_op2", 32'(op2_addr_IFID), 2);
    step();
    chk("lit_ld_d1", 32'(op1_dout_IFID), 24'hABCDEF);
    chk("lit_ld_d2", 32'(op2_dout_IFID), 24'h123456);
    chk("lit_ld_is_load", 32'(IFID_is_load), 1);
    op1_data = 0; op2_data = 0;
    // streaming through, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, {ops[i], 3'(i), 8'(8'h5A ^ 8'(i))}, PCW'(12'h100 + i));
      op1_data = DW'(i * 7);
      step();
      chk("lit_stream_count", 32'(fq_count), 1);
      if (i > 0) chk("lit_stream_pc", 32'(IFID_pc), 12'h100 + i - 1);
    end
    drive(0, 0, 0);
    step();
    chk("lit_stream_last_pc", 32'(IFID_pc), 12'h109);
    chk("lit_stream_empty", 32'(fq_count), 0);
    // reset mid-operation drops queued entries
    stall_ID = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h2222, PCW'(12'h200 + i));
      step();
    end
    drive(0, 0, 0);
    rst = 1;
    step();
    chk("lit_rst_count", 32'(fq_count), 0);
    chk("lit_rst_valid", 32'(IFID_valid), 0);
    chk("lit_rst_ready", 32'(fetch_ready), 0);
    chk("lit_rst_pc", 32'(IFID_pc), 0);
    rst = 0; stall_ID = 0;
    repeat (2) step();
    chk("lit_post_rst_valid", 32'(IFID_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
